// File: rtl/mips32_shift_engine.sv
// mips32_shift_engine: iterative one-bit-per-cycle shifter (modes 00 none, 01 sll, 10 srl/sra, 11 ror) with in_valid/in_ready request and out_valid/out_ready result handshakes, busy while SHIFT/DONE; define MIPS32_SHIFT_STEP4_EN for 4-position steps
module mips32_shift_engine #(
   parameter int DATAWIDTH  = 32,
   parameter int SHAMTWIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            mode,
   input  logic                  arith,
   input  logic [SHAMTWIDTH-1:0] shamt,
   input  logic [DATAWIDTH-1:0]  operand,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATAWIDTH-1:0]  result,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t                state, state_nx;
   logic [DATAWIDTH-1:0]  data, data_nx;
   logic [SHAMTWIDTH-1:0] count, count_nx;
   logic [1:0]            mode_q;
   logic                  arith_q;
   function automatic logic [DATAWIDTH-1:0] step1(input logic [DATAWIDTH-1:0] d, input logic [1:0] m, input logic a);
      step1 = m == 2'b01 ? {d[DATAWIDTH-2:0], 1'b0} :
              m == 2'b10 ? {a & d[DATAWIDTH-1], d[DATAWIDTH-1:1]} :
              m == 2'b11 ? {d[0], d[DATAWIDTH-1:1]} : d;
   endfunction
   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;
   always_comb begin
      state_nx = state;
      data_nx  = data;
      count_nx = count;
      case (state)
         IDLE: if (in_valid) begin
            data_nx  = operand;
            count_nx = shamt;
            state_nx = (mode == 2'b00 || shamt == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
`ifdef MIPS32_SHIFT_STEP4_EN
            data_nx  = count > SHAMTWIDTH'(3) ?
                       step1(step1(step1(step1(data, mode_q, arith_q), mode_q, arith_q), mode_q, arith_q), mode_q, arith_q) :
                       step1(data, mode_q, arith_q);
            count_nx = count > SHAMTWIDTH'(3) ? count - SHAMTWIDTH'(4) : count - SHAMTWIDTH'(1);
            state_nx = count_nx == '0 ? DONE : SHIFT;
`else
            data_nx  = step1(data, mode_q, arith_q);
            count_nx = count - SHAMTWIDTH'(1);
            state_nx = count == SHAMTWIDTH'(1) ? DONE : SHIFT;
`endif
         end
         default: state_nx = out_ready ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data      <= '0;
         count     <= '0;
         mode_q    <= '0;
         arith_q   <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         data      <= data_nx;
         count     <= count_nx;
         out_valid <= state_nx == DONE;
         if (in_valid && in_ready) begin
            mode_q  <= mode;
            arith_q <= arith;
         end
         if (state != DONE && state_nx == DONE) result <= data_nx;
      end
   end
endmodule

// File: tb/tb_mips32_shift_engine.sv
// tb_mips32_shift_engine: directed vectors for mips32_shift_engine
module tb_mips32_shift_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  mode = '0;
   logic        arith = 1'b0;
   logic [4:0]  shamt = '0;
   logic [31:0] operand = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;
   int          n_chk = 0;
   int          n_pass = 0;
   mips32_shift_engine #(.DATAWIDTH(32), .SHAMTWIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .arith(arith), .shamt(shamt), .operand(operand),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   function automatic int exp_lat(input logic [1:0] m, input int sh);
`ifdef MIPS32_SHIFT_STEP4_EN
      exp_lat = (m == 2'b00 || sh == 0) ? 1 : sh / 4 + sh % 4 + 1;
`else
      exp_lat = (m == 2'b00 || sh == 0) ? 1 : sh + 1;
`endif
   endfunction
   task automatic run(input string tag, input logic [1:0] m, input logic a, input logic [4:0] sh, input logic [31:0] op, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      mode = m; arith = a; shamt = sh; operand = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat(m, int'(sh))));
      check({tag, " result"}, result, exp);
   endtask
   task automatic drain(input string tag, input logic [31:0] exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
      check({tag, " result held"}, result, exp);
      out_ready = 1'b0;
   endtask
   initial begin
      #2;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      run("sll4", 2'b01, 1'b0, 5'd4, 32'h0000_0001, 32'h0000_0010);
      @(posedge clk); #1;
      check("sll4 in_ready next", 32'(in_ready), 32'd1);
      check("sll4 out_valid next", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      run("sra31", 2'b10, 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      drain("sra31", 32'hFFFF_FFFF);
      run("srl31", 2'b10, 1'b0, 5'd31, 32'h8000_0000, 32'h0000_0001);
      drain("srl31", 32'h0000_0001);
      run("ror8", 2'b11, 1'b0, 5'd8, 32'h0000_00F1, 32'hF100_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; mode = 2'b01; shamt = 5'd1; operand = 32'h5555_5555;
         @(posedge clk); #1;
         check("ror8 hold out_valid", 32'(out_valid), 32'd1);
         check("ror8 hold result", result, 32'hF100_0000);
         check("ror8 hold in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      drain("ror8", 32'hF100_0000);
      run("none", 2'b00, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      drain("none", 32'hDEAD_BEEF);
      run("sll0", 2'b01, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      drain("sll0", 32'hDEAD_BEEF);
      run("sra4", 2'b10, 1'b1, 5'd4, 32'hF000_0000, 32'hFF00_0000);
      drain("sra4", 32'hFF00_0000);
      run("srl4", 2'b10, 1'b0, 5'd4, 32'hF000_0000, 32'h0F00_0000);
      drain("srl4", 32'h0F00_0000);
      run("sra4pos", 2'b10, 1'b1, 5'd4, 32'h1234_5678, 32'h0123_4567);
      drain("sra4pos", 32'h0123_4567);
      run("ror31", 2'b11, 1'b0, 5'd31, 32'h8000_0001, 32'h0000_0003);
      drain("ror31", 32'h0000_0003);
      run("sll9", 2'b01, 1'b0, 5'd9, 32'h0000_0001, 32'h0000_0200);
      drain("sll9", 32'h0000_0200);
      @(negedge clk);
      mode = 2'b01; arith = 1'b0; shamt = 5'd10; operand = 32'h0000_0001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort busy before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run("after abort", 2'b01, 1'b0, 5'd2, 32'h0000_0003, 32'h0000_000C);
      drain("after abort", 32'h0000_000C);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mips32_shift_engine.md
Name: mips32_shift_engine

Overview:
Iterative multi-cycle shifter that computes the shifted operand consumed by the datapath's shift-result mux.
- Accepts operand, shift amount and shift mode over a valid/ready handshake.
- Shifts one bit position per cycle.
- Presents the result over a second valid/ready handshake.
- Mode encoding matches the shift mux select: 00 none, 01 logic left, 10 arithmetic/logic right, 11 rotate right.

Parameters:
DATAWIDTH, 32, operand/result width
SHAMTWIDTH, 5, shift amount width; must satisfy 2**SHAMTWIDTH >= DATAWIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  engine can accept a request
mode  input  2  00 none, 01 logic left, 10 right, 11 rotate right
arith  input  1  mode 10 only: 1 = sign fill, 0 = zero fill
shamt  input  SHAMTWIDTH  shift amount
operand  input  DATAWIDTH  value to shift
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  DATAWIDTH  shifted value
busy  output  1  high in SHIFT or DONE

Behaviour:
- States: IDLE, SHIFT, DONE. Reset is asynchronous on rst_n low.
- Reset values: state IDLE, out_valid 0, result 0, internal count 0.
- Outputs during reset: in_ready 1 and busy 0, because both decode from state.
- in_ready = (state == IDLE). Accept occurs when in_valid && in_ready at the clock edge.
- Accept latches operand into the data register, and latches shamt, mode and arith.
- After accept, mode == 00 or shamt == 0 goes to DONE; otherwise SHIFT with count = shamt.
- SHIFT, every cycle, count decrements by 1 and the data register shifts one position:
  - 01: left shift, 0 into LSB.
  - 10: right shift; MSB fill is data[MSB] if arith == 1, else 0.
  - 11: rotate right, data[0] moves to MSB.
- SHIFT to DONE when count == 1 at the edge, i.e. the last step is taken on that edge.
- Latency: out_valid asserts shamt+1 cycles after the accept edge (1 cycle for mode 00 or shamt 0).
- DONE: out_valid = 1, result = data register, held stable until out_ready.
- On out_valid && out_ready: go to IDLE and clear out_valid.
  - in_ready rises in the same cycle IDLE is entered.
  - Back-to-back accept is possible one cycle after the output handshake.
- No overlap: in_valid is ignored while busy. Input fields change freely outside the accept edge.
- shamt >= DATAWIDTH, modes 01 and 10: the result saturates to all-zero or all-sign; no error is flagged.
- shamt >= DATAWIDTH, mode 11: rotates by the full shamt count (modulo behaviour falls out naturally).
- Reset mid-SHIFT or mid-DONE: the operation is aborted with no out_valid pulse, and the pending result is discarded.
- result holds its last value in IDLE; it updates only on the SHIFT-to-DONE or IDLE-to-DONE edge.

Optional Feature:
MIPS32_SHIFT_STEP4_EN
- Defined: in SHIFT, if count >= 4 the data register shifts 4 positions in one cycle and count decreases by 4; otherwise it shifts 1 position.
  - Fill and rotate rules are the same as the single-bit step, applied per position.
  - Latency from accept to out_valid = floor(shamt/4) + (shamt mod 4) + 1.
  - Exit to DONE when the remaining count reaches 0 after the step.
- Undefined: single-bit stepping only, latency as in Behaviour.

Test Plan:
- Mode 01, operand 0x0000_0001, shamt 4, out_ready held 1 -> out_valid 5 cycles after accept, result 0x0000_0010, in_ready high next cycle.
- Mode 10, arith 1, operand 0x8000_0000, shamt 31 -> result 0xFFFF_FFFF, out_valid 32 cycles after accept; with arith 0 -> 0x0000_0001.
- Mode 11, operand 0x0000_00F1, shamt 8 -> result 0xF100_0000. Hold out_ready 0 for 3 cycles -> out_valid and result stable, in_ready 0, new in_valid ignored.
- Mode 00 or shamt 0, operand 0xDEAD_BEEF -> out_valid 1 cycle after accept, result 0xDEAD_BEEF.
- rst_n low 3 cycles into a shamt 10 left shift -> immediately IDLE, out_valid 0, result 0, in_ready 1. Next request completes correctly.
- With MIPS32_SHIFT_STEP4_EN: mode 01, operand 1, shamt 9 -> result 0x0000_0200, out_valid 4 cycles after accept.
